// File: rtl/demux_1_2_buf.sv
// 1:2 demultiplexer with a one-entry buffer per output and valid/ready handshakes.
// Optional per-output drain counters are built only when DEMUX_CNT_EN is defined.
module demux_1_2_buf #(
    parameter int N = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] IN_DATA,
    input  logic         IN_SEL,
    input  logic         IN_VALID,
    output logic         IN_READY,
    output logic [N-1:0] OUT_A,
    output logic [N-1:0] OUT_B,
    output logic         OUT_A_VALID,
    output logic         OUT_B_VALID,
    input  logic         OUT_A_READY,
    input  logic         OUT_B_READY,
    output logic [15:0]  CNT_A,
    output logic [15:0]  CNT_B
);

    logic         full_a_q, full_a_d;
    logic         full_b_q, full_b_d;
    logic [N-1:0] data_a_q, data_a_d;
    logic [N-1:0] data_b_q, data_b_d;
    logic         drain_a, drain_b;
    logic         load_a, load_b;
    logic         rdy_a, rdy_b;

    // A full buffer can still accept when its consumer frees it this cycle.
    always_comb begin
        rdy_a    = !full_a_q || OUT_A_READY;
        rdy_b    = !full_b_q || OUT_B_READY;
        IN_READY = IN_SEL ? rdy_b : rdy_a;
        drain_a  = full_a_q && OUT_A_READY;
        drain_b  = full_b_q && OUT_B_READY;
        load_a   = IN_VALID && !IN_SEL && rdy_a;
        load_b   = IN_VALID && IN_SEL && rdy_b;
    end

    always_comb begin
        full_a_d = load_a || (full_a_q && !drain_a);
        full_b_d = load_b || (full_b_q && !drain_b);
        data_a_d = load_a ? IN_DATA : data_a_q;
        data_b_d = load_b ? IN_DATA : data_b_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            full_a_q <= 1'b0;
            full_b_q <= 1'b0;
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            full_a_q <= full_a_d;
            full_b_q <= full_b_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
        end
    end

    assign OUT_A       = data_a_q;
    assign OUT_B       = data_b_q;
    assign OUT_A_VALID = full_a_q;
    assign OUT_B_VALID = full_b_q;

`ifdef DEMUX_CNT_EN
    logic [15:0] cnt_a_q, cnt_a_d;
    logic [15:0] cnt_b_q, cnt_b_d;

    always_comb begin
        cnt_a_d = drain_a ? cnt_a_q + 16'd1 : cnt_a_q;
        cnt_b_d = drain_b ? cnt_b_q + 16'd1 : cnt_b_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign CNT_A = cnt_a_q;
    assign CNT_B = cnt_b_q;
`else
    assign CNT_A = '0;
    assign CNT_B = '0;
`endif

endmodule

// File: tb/tb_demux_1_2_buf.sv
// Directed plus random bench for demux_1_2_buf, checked against a queue-based
// model of the two one-entry output buffers and their drain counters.
module tb_demux_1_2_buf;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] IN_DATA;
    logic        IN_SEL;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] OUT_A, OUT_B;
    logic        OUT_A_VALID, OUT_B_VALID;
    logic        OUT_A_READY, OUT_B_READY;
    logic [15:0] CNT_A, CNT_B;

    int checks = 0;
    int failures = 0;

    // model: pending words, last loaded word, drain count, drain log
    logic [31:0] qa[$], qb[$];
    logic [31:0] log_a[$], log_b[$];
    logic [31:0] last_a, last_b;
    logic [15:0] cnt_a, cnt_b;

    demux_1_2_buf #(.N(32)) dut (
        .CLK(CLK), .RST(RST),
        .IN_DATA(IN_DATA), .IN_SEL(IN_SEL),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OUT_A(OUT_A), .OUT_B(OUT_B),
        .OUT_A_VALID(OUT_A_VALID), .OUT_B_VALID(OUT_B_VALID),
        .OUT_A_READY(OUT_A_READY), .OUT_B_READY(OUT_B_READY),
        .CNT_A(CNT_A), .CNT_B(CNT_B)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs();
        logic [15:0] ea, eb;
`ifdef DEMUX_CNT_EN
        ea = cnt_a;
        eb = cnt_b;
`else
        ea = 16'd0;
        eb = 16'd0;
`endif
        chk("a_valid", OUT_A_VALID, qa.size() != 0);
        chk("b_valid", OUT_B_VALID, qb.size() != 0);
        chk("out_a", OUT_A, last_a);
        chk("out_b", OUT_B, last_b);
        chk("cnt_a", CNT_A, ea);
        chk("cnt_b", CNT_B, eb);
    endtask

    // One clock: drive at posedge+1, check pre-edge, advance model, check post-edge.
    task automatic cyc(input logic [31:0] d, input logic s, input logic v,
                       input logic ra, input logic rb);
        logic exp_rdy;
        IN_DATA = d; IN_SEL = s; IN_VALID = v;
        OUT_A_READY = ra; OUT_B_READY = rb;
        #1;
        exp_rdy = s ? (qb.size() == 0 || rb) : (qa.size() == 0 || ra);
        chk("in_ready", IN_READY, exp_rdy);
        if (qa.size() != 0 && ra) begin
            chk("drain_a", OUT_A, qa[0]);
            log_a.push_back(qa.pop_front());
            cnt_a = cnt_a + 16'd1;
        end
        if (qb.size() != 0 && rb) begin
            chk("drain_b", OUT_B, qb[0]);
            log_b.push_back(qb.pop_front());
            cnt_b = cnt_b + 16'd1;
        end
        if (v && exp_rdy) begin
            if (s) begin qb.push_back(d); last_b = d; end
            else   begin qa.push_back(d); last_a = d; end
        end
        @(posedge CLK); #1;
        chk_outs();
    endtask

    task automatic rst_cyc(input logic [31:0] d, input logic s, input logic v);
        RST = 1'b1;
        IN_DATA = d; IN_SEL = s; IN_VALID = v;
        OUT_A_READY = 1'b0; OUT_B_READY = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        qa.delete(); qb.delete();
        last_a = '0; last_b = '0;
        cnt_a = '0; cnt_b = '0;
        chk_outs();
        chk("rdy_after_rst", IN_READY, 1'b1);
    endtask

    initial begin
        int ones;
        int guard;
        RST = 1'b1; IN_DATA = '0; IN_SEL = 1'b0; IN_VALID = 1'b0;
        OUT_A_READY = 1'b0; OUT_B_READY = 1'b0;
        last_a = '0; last_b = '0; cnt_a = '0; cnt_b = '0;
        @(posedge CLK); #1;
        rst_cyc(32'hCAFE0000, 1'b0, 1'b1);

        // single word to A
        cyc(32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("dead_a", OUT_A, 32'hDEADBEEF);
        chk("dead_bv", OUT_B_VALID, 1'b0);

        // A blocked, B still free
        cyc(32'h11111111, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("hold_a", OUT_A, 32'hDEADBEEF);
        cyc(32'h22222222, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("land_b", OUT_B, 32'h22222222);

        // simultaneous drain and load, no bubble
        cyc(32'h1, 1'b0, 1'b1, 1'b1, 1'b0);
        log_a.delete();
        cyc(32'h2, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("replace_a", OUT_A, 32'h2);
        chk("replace_av", OUT_A_VALID, 1'b1);
        ones = 0;
        foreach (log_a[i]) if (log_a[i] == 32'h1) ones++;
        chk("seen_one_once", ones, 1);

        // alternating back-to-back stream
        cyc(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        log_a.delete(); log_b.delete();
        for (int i = 1; i <= 8; i++)
            cyc(i, (i % 2) == 0, 1'b1, 1'b1, 1'b1);
        cyc(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("stream_a_len", log_a.size(), 4);
        chk("stream_b_len", log_b.size(), 4);
        for (int i = 0; i < 4 && i < log_a.size() && i < log_b.size(); i++) begin
            chk("stream_a", log_a[i], 2 * i + 1);
            chk("stream_b", log_b[i], 2 * i + 2);
        end

        // random traffic
        for (int i = 0; i < 400; i++)
            cyc($urandom, 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom));

        // reset while both buffers are full
        cyc(32'hAAAA5555, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(32'h5555AAAA, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("both_full", {OUT_A_VALID, OUT_B_VALID}, 2'b11);
        rst_cyc(32'h12345678, 1'b1, 1'b1);
        chk("rst_av", OUT_A_VALID, 1'b0);
        chk("rst_out_b", OUT_B, 32'h0);

`ifdef DEMUX_CNT_EN
        guard = 0;
        while (cnt_a != 16'hFFFF && guard < 70000) begin
            cyc(guard, 1'b0, 1'b1, 1'b1, 1'b0);
            guard++;
        end
        chk("preset_reached", cnt_a, 16'hFFFF);
        chk("preset_cnt_a", CNT_A, 16'hFFFF);
        cyc(32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("cnt_wrap", CNT_A, 16'h0);
`else
        guard = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(i, 1'b0, 1'b1, 1'b1, 1'b1);
            guard++;
        end
        chk("cnt_off", CNT_A, 16'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_1_2_buf.md
DEMUX_1_2_BUF -- requirements
Module: demux_1_2_buf

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the data width in bits.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port IN_DATA, input, N bits: the incoming word.
REQ-005 The block SHALL have port IN_SEL, input, 1 bit: the destination, 0 for port A and 1 for port B.
REQ-006 The block SHALL have port IN_VALID, input, 1 bit: IN_DATA and IN_SEL are valid.
REQ-007 The block SHALL have port IN_READY, output, 1 bit: the block accepts the word this cycle.
REQ-008 The block SHALL have ports OUT_A and OUT_B, output, N bits each: the buffered words.
REQ-009 The block SHALL have ports OUT_A_VALID and OUT_B_VALID, output, 1 bit each: the matching buffer holds a word.
REQ-010 The block SHALL have ports OUT_A_READY and OUT_B_READY, input, 1 bit each: the consumer takes the word.
REQ-011 The block SHALL have ports CNT_A and CNT_B, output, 16 bits each: transfer counters (see Configuration).

Function
REQ-012 A transfer SHALL occur at a rising CLK edge when valid and ready are both 1 on the same interface.
REQ-013 Each output SHALL own a one-entry buffer with states EMPTY and FULL; OUT_x_VALID SHALL be 1 exactly when the buffer is FULL.
REQ-014 IN_READY SHALL be combinational: 1 when the buffer selected by IN_SEL is EMPTY, or is FULL with OUT_x_READY=1; otherwise 0.
REQ-015 An input transfer SHALL load IN_DATA into the buffer chosen by IN_SEL; the word appears on OUT_x with OUT_x_VALID=1 one cycle later (latency 1).
REQ-016 Buffer transitions SHALL be: EMPTY->FULL on load; FULL->EMPTY on drain with no load; FULL->FULL on simultaneous drain and load, with the new word replacing the old word, no bubble and no loss.
REQ-017 The unselected buffer SHALL be unaffected by input activity; it SHALL keep draining independently in the same cycle.
REQ-018 OUT_x SHALL hold its value while OUT_x_VALID=1 and OUT_x_READY=0; IN_VALID=0 SHALL change no state.
REQ-019 OUT_x SHALL keep the last drained word while its buffer is EMPTY; consumers ignore it.
REQ-020 Words to the same output SHALL leave in arrival order; no ordering SHALL be guaranteed between A and B.

Reset
REQ-021 While RST=1 at a rising edge, both buffers SHALL go EMPTY, and OUT_A, OUT_B, CNT_A and CNT_B SHALL go to 0.
REQ-022 During the reset cycle, any word presented SHALL be discarded; a buffered word SHALL be lost on reset mid-operation.
REQ-023 IN_READY SHALL be 1 in the first cycle after reset release.

Configuration
REQ-024 Macro DEMUX_CNT_EN SHALL enable the transfer counters.
REQ-025 When DEMUX_CNT_EN is defined, CNT_x SHALL increment by 1 on each OUT_x drain transfer and wrap from 16'hFFFF to 16'h0000.
REQ-026 When DEMUX_CNT_EN is not defined, CNT_A and CNT_B SHALL be constant 0 and no counter flops SHALL be present.
REQ-027 Data-path behaviour SHALL be identical with and without the macro.

Verification
REQ-028 Reset, then IN_DATA=32'hDEADBEEF, IN_SEL=0, IN_VALID=1 for one cycle -> next cycle OUT_A=32'hDEADBEEF, OUT_A_VALID=1, OUT_B_VALID=0.
REQ-029 Buffer A FULL, OUT_A_READY=0, IN_SEL=0, IN_VALID=1 -> IN_READY=0; OUT_A holds its value. Then IN_SEL=1 -> IN_READY=1 and the word lands in B.
REQ-030 Buffer A FULL with 32'h1, OUT_A_READY=1, input 32'h2 to A in the same cycle -> next cycle OUT_A=32'h2, OUT_A_VALID=1; the consumer saw 32'h1 exactly once.
REQ-031 Back-to-back stream 1..8, alternating IN_SEL, both READY=1 -> IN_READY stays 1; A receives 1,3,5,7 and B receives 2,4,6,8, in order.
REQ-032 RST=1 asserted while both buffers are FULL -> next cycle both VALID=0, OUT_A=OUT_B=0, CNT_A=CNT_B=0.
REQ-033 With DEMUX_CNT_EN defined, CNT_A preset by 65535 drains, then one more drain -> CNT_A=0. Without the macro, CNT_A=0 throughout.
